inv_reg_pipe: RTL and testbench

INV_REG_PIPE -- requirements
Module: inv_reg_pipe

---
 rtl/inv_reg_pipe.sv | 95 +++++++++
 tb/tb_inv_reg_pipe.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_reg_pipe.sv
// Register pipeline that captures d_in XOR INV_MASK once warm-up completes.
// It counts valid output value changes with a saturating counter.
module inv_reg_pipe #(
    parameter int               WIDTH    = 8,
    parameter int               DEPTH    = 2,
    parameter logic [WIDTH-1:0] INV_MASK = {WIDTH{1'b1}}
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_in,
    input  logic             in_valid,
    input  logic             stall,
    output logic [WIDTH-1:0] d_out,
    output logic             out_valid,
    output logic             rdy,
    output logic [15:0]      toggle_cnt
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {ST_RESET, ST_WARMUP, ST_READY} state_t;

    state_t                      state_reg;
    state_t                      state_next;
    logic [CW-1:0]               warm_reg;
    logic [CW:0]                 warm_inc;
    logic                        ready;

    logic [DEPTH-1:0][WIDTH-1:0] data_reg;
    logic [DEPTH-1:0]            valid_reg;
    logic [DEPTH-1:0][WIDTH-1:0] data_next;
    logic [DEPTH-1:0]            valid_next;
    logic [15:0]                 toggle_reg;

    assign warm_inc = {1'b0, warm_reg} + (CW+1)'(1);

    always_ff @(posedge clock) begin
        if (rst) begin
            state_reg <= ST_RESET;
            warm_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (warm_reg != CW'(DEPTH))
                warm_reg <= warm_inc[CW-1:0];
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RESET, ST_WARMUP:
                state_next = (warm_inc >= (CW+1)'(DEPTH)) ? ST_READY : ST_WARMUP;
            ST_READY:
                state_next = ST_READY;
            default:
                state_next = ST_RESET;
        endcase
    end

    always_comb begin
        ready = (state_reg == ST_READY);
        rdy   = ready;
    end

    // Bubbles carry zero data so nothing stale ever leaks to d_out.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage_in
            if (gi == 0) begin : g_head
                assign valid_next[gi] = ready & in_valid;
                assign data_next[gi]  = (ready & in_valid) ? (d_in ^ INV_MASK) : '0;
            end else begin : g_body
                assign valid_next[gi] = valid_reg[gi-1];
                assign data_next[gi]  = data_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (rst) begin
            data_reg   <= '0;
            valid_reg  <= '0;
            toggle_reg <= '0;
        end else if (!stall) begin
            data_reg  <= data_next;
            valid_reg <= valid_next;
            if (valid_next[DEPTH-1] && data_next[DEPTH-1] != data_reg[DEPTH-1]
                    && toggle_reg != 16'hFFFF)
                toggle_reg <= toggle_reg + 16'd1;
        end
    end

    assign d_out      = data_reg[DEPTH-1];
    assign out_valid  = valid_reg[DEPTH-1];
    assign toggle_cnt = toggle_reg;

endmodule

// File: tb/tb_inv_reg_pipe.sv
// Directed bench for inv_reg_pipe: default DUT (DEPTH=2, mask FF) plus a
// DEPTH=1 / mask 0F variant used for latency-1 and counter saturation.
module tb_inv_reg_pipe;
    logic        clock = 1'b0;
    logic        rst;
    logic [7:0]  d_in, d_in2;
    logic        in_valid, in_valid2;
    logic        stall;
    logic [7:0]  d_out, d_out2;
    logic        out_valid, out_valid2;
    logic        rdy, rdy2;
    logic [15:0] toggle_cnt, toggle_cnt2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    inv_reg_pipe #(.WIDTH(8), .DEPTH(2), .INV_MASK(8'hFF)) u_dut (
        .clock(clock), .rst(rst), .d_in(d_in), .in_valid(in_valid), .stall(stall),
        .d_out(d_out), .out_valid(out_valid), .rdy(rdy), .toggle_cnt(toggle_cnt)
    );

    inv_reg_pipe #(.WIDTH(8), .DEPTH(1), .INV_MASK(8'h0F)) u_var (
        .clock(clock), .rst(rst), .d_in(d_in2), .in_valid(in_valid2), .stall(1'b0),
        .d_out(d_out2), .out_valid(out_valid2), .rdy(rdy2), .toggle_cnt(toggle_cnt2)
    );

    task automatic step(input string tag);
        @(posedge clock);
        #1;
        $display("tx %-12s rst=%0b stall=%0b in=%02h/%0b -> d_out=%02h ov=%0b rdy=%0b cnt=%0d",
                 tag, rst, stall, d_in, in_valid, d_out, out_valid, rdy, toggle_cnt);
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; d_in = 8'h00; in_valid = 1'b0;
        d_in2 = 8'h00; in_valid2 = 1'b0;
        step("reset");
        step("reset");
        n_vec++;
        if (d_out !== 8'h00 || out_valid !== 1'b0 || rdy !== 1'b0 || toggle_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL reset_state: got d_out=%02h ov=%0b rdy=%0b cnt=%0d, want 00 0 0 0",
                     d_out, out_valid, rdy, toggle_cnt);
        end
        rst = 1'b0;
        step("warmup1");
        n_vec++;
        if (rdy !== 1'b0 || d_out !== 8'h00 || out_valid !== 1'b0 || toggle_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL warmup_edge1: got rdy=%0b d_out=%02h ov=%0b cnt=%0d, want 0 00 0 0",
                     rdy, d_out, out_valid, toggle_cnt);
        end
        step("warmup2");
        n_vec++;
        if (rdy !== 1'b1 || d_out !== 8'h00 || out_valid !== 1'b0 || toggle_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL warmup_edge2: got rdy=%0b d_out=%02h ov=%0b cnt=%0d, want 1 00 0 0",
                     rdy, d_out, out_valid, toggle_cnt);
        end
    endtask

    task automatic test_single();
        d_in = 8'h3C; in_valid = 1'b1;
        step("single_cap");
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_latency: got ov=%0b after 1 edge, want 0", out_valid);
        end
        d_in = 8'h00; in_valid = 1'b0;
        step("single_out");
        n_vec++;
        if (d_out !== 8'hC3 || out_valid !== 1'b1 || toggle_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL single_word: got d_out=%02h ov=%0b cnt=%0d, want C3 1 1",
                     d_out, out_valid, toggle_cnt);
        end
        step("single_bub");
        n_vec++;
        if (d_out !== 8'h00 || out_valid !== 1'b0 || toggle_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL single_bubble: got d_out=%02h ov=%0b cnt=%0d, want 00 0 1",
                     d_out, out_valid, toggle_cnt);
        end
    endtask

    task automatic test_stall();
        d_in = 8'h01; in_valid = 1'b1;
        step("stall_w1");
        d_in = 8'h02;
        step("stall_w2");
        stall = 1'b1; d_in = 8'h99;
        for (int i = 0; i < 3; i++) begin
            step("stall_hold");
            n_vec++;
            if (d_out !== 8'hFE || out_valid !== 1'b1 || toggle_cnt !== 16'd2) begin
                n_err++;
                $display("FAIL stall_hold%0d: got d_out=%02h ov=%0b cnt=%0d, want FE 1 2",
                         i, d_out, out_valid, toggle_cnt);
            end
        end
        stall = 1'b0; in_valid = 1'b0; d_in = 8'h00;
        step("stall_rel");
        n_vec++;
        if (d_out !== 8'hFD || out_valid !== 1'b1 || toggle_cnt !== 16'd3) begin
            n_err++;
            $display("FAIL stall_release: got d_out=%02h ov=%0b cnt=%0d, want FD 1 3",
                     d_out, out_valid, toggle_cnt);
        end
        step("stall_tail");
        n_vec++;
        if (d_out !== 8'h00 || out_valid !== 1'b0 || toggle_cnt !== 16'd3) begin
            n_err++;
            $display("FAIL stall_tail: got d_out=%02h ov=%0b cnt=%0d, want 00 0 3",
                     d_out, out_valid, toggle_cnt);
        end
    endtask

    task automatic test_equal();
        logic [7:0] ins [3];
        logic [7:0] exp [3];
        ins = '{8'h3C, 8'h3C, 8'h55};
        exp = '{8'hC3, 8'hC3, 8'hAA};
        for (int i = 0; i < 5; i++) begin
            in_valid = (i < 3);
            d_in     = (i < 3) ? ins[i] : 8'h00;
            step("equal");
            if (i >= 1 && i <= 3) begin
                n_vec++;
                if (d_out !== exp[i-1] || out_valid !== 1'b1) begin
                    n_err++;
                    $display("FAIL equal_seq%0d: got d_out=%02h ov=%0b, want %02h 1",
                             i - 1, d_out, out_valid, exp[i-1]);
                end
            end
        end
        n_vec++;
        if (toggle_cnt !== 16'd5 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL equal_count: got cnt=%0d ov=%0b, want 5 0", toggle_cnt, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [3];
        exp = '{8'hEF, 8'hDF, 8'hCF};
        for (int i = 0; i < 5; i++) begin
            in_valid = (i < 3);
            d_in     = (i < 3) ? 8'((i + 1) * 16) : 8'h00;
            step("b2b");
            if (i >= 1 && i <= 3) begin
                n_vec++;
                if (d_out !== exp[i-1] || out_valid !== 1'b1 || toggle_cnt !== 16'(5 + i)) begin
                    n_err++;
                    $display("FAIL b2b_word%0d: got d_out=%02h ov=%0b cnt=%0d, want %02h 1 %0d",
                             i - 1, d_out, out_valid, toggle_cnt, exp[i-1], 5 + i);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        d_in = 8'h11; in_valid = 1'b1;
        step("mid_word");
        rst = 1'b1; stall = 1'b1;
        step("mid_rst");
        n_vec++;
        if (d_out !== 8'h00 || out_valid !== 1'b0 || rdy !== 1'b0 || toggle_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL mid_reset: got d_out=%02h ov=%0b rdy=%0b cnt=%0d, want 00 0 0 0",
                     d_out, out_valid, rdy, toggle_cnt);
        end
        rst = 1'b0; stall = 1'b0; d_in = 8'h77; in_valid = 1'b1;
        step("mid_pulse");
        n_vec++;
        if (rdy !== 1'b0) begin
            n_err++;
            $display("FAIL mid_warm1: got rdy=%0b, want 0", rdy);
        end
        in_valid = 1'b0; d_in = 8'h00;
        step("mid_warm2");
        n_vec++;
        if (rdy !== 1'b1 || out_valid !== 1'b0 || d_out !== 8'h00) begin
            n_err++;
            $display("FAIL mid_warm2: got rdy=%0b ov=%0b d_out=%02h, want 1 0 00",
                     rdy, out_valid, d_out);
        end
        for (int i = 0; i < 2; i++) begin
            step("mid_drain");
            n_vec++;
            if (out_valid !== 1'b0 || d_out !== 8'h00 || toggle_cnt !== 16'd0) begin
                n_err++;
                $display("FAIL mid_pulse_leak%0d: got ov=%0b d_out=%02h cnt=%0d, want 0 00 0",
                         i, out_valid, d_out, toggle_cnt);
            end
        end
    endtask

    task automatic test_variant();
        n_vec++;
        if (rdy2 !== 1'b1) begin
            n_err++;
            $display("FAIL var_rdy: got rdy=%0b, want 1", rdy2);
        end
        d_in2 = 8'hA5; in_valid2 = 1'b1;
        step("var_word");
        n_vec++;
        if (d_out2 !== 8'hAA || out_valid2 !== 1'b1 || toggle_cnt2 !== 16'd1) begin
            n_err++;
            $display("FAIL var_latency1: got d_out=%02h ov=%0b cnt=%0d, want AA 1 1",
                     d_out2, out_valid2, toggle_cnt2);
        end
        for (int i = 0; i < 65540; i++) begin
            d_in2 = (i % 2 == 0) ? 8'h5A : 8'hA5;
            @(posedge clock);
            #1;
        end
        $display("tx var_preload  d_out=%02h cnt=%0d", d_out2, toggle_cnt2);
        n_vec++;
        if (toggle_cnt2 !== 16'hFFFF) begin
            n_err++;
            $display("FAIL var_saturate: got cnt=%04h, want FFFF", toggle_cnt2);
        end
        d_in2 = (d_out2 == 8'hAA) ? 8'h5A : 8'hA5;
        step("var_sat");
        n_vec++;
        if (toggle_cnt2 !== 16'hFFFF || out_valid2 !== 1'b1) begin
            n_err++;
            $display("FAIL var_no_wrap: got cnt=%04h ov=%0b, want FFFF 1", toggle_cnt2, out_valid2);
        end
        in_valid2 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_equal();
        test_back_to_back();
        test_reset_mid();
        test_variant();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
